// File: rtl/tomasulo_pkg.sv
// Shared definitions for the reservation-station dispatch slice: opcode
// encodings, default widths, the entry record and the CDB tag-match helper.
package tomasulo_pkg;

   localparam int DATA_W = 8;
   localparam int TAG_W  = 3;
   localparam int REG_W  = 4;
   localparam int FUNC_W = 4;

   localparam logic [FUNC_W-1:0] FUNC_ADD = 4'b0000;
   localparam logic [FUNC_W-1:0] FUNC_SUB = 4'b0001;
   localparam logic [FUNC_W-1:0] FUNC_MUL = 4'b0010;
   localparam logic [FUNC_W-1:0] FUNC_DIV = 4'b0011;
   localparam logic [FUNC_W-1:0] FUNC_LD  = 4'b0100;
   localparam logic [FUNC_W-1:0] FUNC_ST  = 4'b0101;

   // One reservation-station slot; the age relation lives in rs_age_select.
   typedef struct packed {
      logic              busy;
      logic [FUNC_W-1:0] func;
      logic [REG_W-1:0]  rd;
      logic [TAG_W-1:0]  rob;
      logic              rdy1;
      logic [DATA_W-1:0] v1;
      logic [TAG_W-1:0]  q1;
      logic              rdy2;
      logic [DATA_W-1:0] v2;
      logic [TAG_W-1:0]  q2;
   } rs_entry_t;

   // True when a broadcast supplies an operand that is still waiting on tag q.
   function automatic logic tag_hit(input logic             cdb_v,
                                    input logic [TAG_W-1:0] cdb_tag,
                                    input logic             rdy,
                                    input logic [TAG_W-1:0] q);
      return cdb_v && !rdy && (cdb_tag == q);
   endfunction

endpackage

// File: rtl/rs_dispatch_if.sv
// Issue/CDB/dispatch bundle of one reservation-station bank. The slave side
// is the bank; the master side is the surrounding issue logic, CDB and
// execution unit.
interface rs_dispatch_if #(
   parameter int NUM_ENT = 3,
   parameter int DATA_W  = 8,
   parameter int TAG_W   = 3,
   parameter int FUNC_W  = 4,
   parameter int REG_W   = 4
);
   localparam int IDX_W = (NUM_ENT > 1) ? $clog2(NUM_ENT) : 1;
   // The output register can hold one op on top of NUM_ENT busy entries.
   localparam int CNT_W = $clog2(NUM_ENT + 2);

   logic              flush;
   logic              alloc_valid;
   logic              alloc_ready;
   logic [FUNC_W-1:0] alloc_func;
   logic [REG_W-1:0]  alloc_rd;
   logic [TAG_W-1:0]  alloc_rob;
   logic              alloc_rdy1;
   logic              alloc_rdy2;
   logic [DATA_W-1:0] alloc_v1;
   logic [DATA_W-1:0] alloc_v2;
   logic [TAG_W-1:0]  alloc_q1;
   logic [TAG_W-1:0]  alloc_q2;
   logic              cdb_valid;
   logic [TAG_W-1:0]  cdb_rob;
   logic [DATA_W-1:0] cdb_data;
   logic              exec_ready;
   logic              exec_b;
   logic [FUNC_W-1:0] func;
   logic [IDX_W-1:0]  rs_index;
   logic [DATA_W-1:0] rs1_data;
   logic [DATA_W-1:0] rs2_data;
   logic [TAG_W-1:0]  rob_ind;
   logic [REG_W-1:0]  rd;
   logic [CNT_W-1:0]  busy_cnt;

   modport slave (
      input  flush, alloc_valid, alloc_func, alloc_rd, alloc_rob,
             alloc_rdy1, alloc_rdy2, alloc_v1, alloc_v2, alloc_q1, alloc_q2,
             cdb_valid, cdb_rob, cdb_data, exec_ready,
      output alloc_ready, exec_b, func, rs_index, rs1_data, rs2_data,
             rob_ind, rd, busy_cnt
   );

   modport master (
      output flush, alloc_valid, alloc_func, alloc_rd, alloc_rob,
             alloc_rdy1, alloc_rdy2, alloc_v1, alloc_v2, alloc_q1, alloc_q2,
             cdb_valid, cdb_rob, cdb_data, exec_ready,
      input  alloc_ready, exec_b, func, rs_index, rs1_data, rs2_data,
             rob_ind, rd, busy_cnt
   );

endinterface

// File: rtl/rs_age_select.sv
// Age matrix for the reservation-station entries plus oldest-eligible pick.
// age_q[i][j] = 1 means entry i was allocated before entry j. A new entry
// clears its row (younger than everyone) and sets its column in every other
// row. Stale rows of free entries are harmless: free entries are never
// eligible and their row is rewritten on the next allocation.
module rs_age_select #(
   parameter int NUM_ENT = 3,
   parameter int IDX_W   = 2
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic               flush_i,
   input  logic               alloc_i,
   input  logic [NUM_ENT-1:0] alloc_oh_i,
   input  logic [NUM_ENT-1:0] free_oh_i,
   input  logic [NUM_ENT-1:0] elig_i,
   output logic [NUM_ENT-1:0] sel_oh_o,
   output logic [IDX_W-1:0]   sel_idx_o,
   output logic               sel_any_o
);

   logic [NUM_ENT-1:0] age_q [NUM_ENT];
   logic [NUM_ENT-1:0] age_d [NUM_ENT];

   // Age-matrix update for entries leaving and entering the bank
   always_comb begin
      for (int i = 0; i < NUM_ENT; i++) begin
         age_d[i] = free_oh_i[i] ? '0 : age_q[i];
      end
      if (alloc_i) begin
         for (int k = 0; k < NUM_ENT; k++) begin
            if (alloc_oh_i[k]) begin
               age_d[k] = '0;
               for (int j = 0; j < NUM_ENT; j++) begin
                  if (j != k) age_d[j][k] = 1'b1;
               end
            end
         end
      end
   end

   // Age-matrix register
   always_ff @(posedge clk_i) begin
      if (!rst_ni || flush_i) begin
         for (int i = 0; i < NUM_ENT; i++) age_q[i] <= '0;
      end else begin
         age_q <= age_d;
      end
   end

   // An eligible entry wins if it is older than every other eligible entry
   always_comb begin
      sel_oh_o  = '0;
      sel_idx_o = '0;
      sel_any_o = |elig_i;
      for (int i = 0; i < NUM_ENT; i++) begin
         sel_oh_o[i] = elig_i[i] &
                       ~|(elig_i & ~age_q[i] & ~(NUM_ENT'(1) << i));
      end
      for (int i = 0; i < NUM_ENT; i++) begin
         if (sel_oh_o[i]) sel_idx_o = IDX_W'(i);
      end
   end

endmodule

// File: rtl/rs_dispatch.sv
// Reservation-station bank for one functional-unit class. Captures renamed
// ops, snoops the CDB for missing operands and keeps the oldest fully-ready
// op in a registered dispatch slot for the execution unit.
module rs_dispatch #(
   parameter int NUM_ENT = 3,
   parameter int DATA_W  = 8,
   parameter int TAG_W   = 3,
   parameter int FUNC_W  = 4,
   parameter int REG_W   = 4
) (
   input logic          clk1,
   input logic          rst_n,
   rs_dispatch_if.slave bus
);
   import tomasulo_pkg::*;

   localparam int IDX_W = (NUM_ENT > 1) ? $clog2(NUM_ENT) : 1;
   localparam int CNT_W = $clog2(NUM_ENT + 2);

   rs_entry_t          ent_q [NUM_ENT];
   rs_entry_t          ent_d [NUM_ENT];
   logic [NUM_ENT-1:0] busy_v;
   logic [NUM_ENT-1:0] elig_v;
   logic [NUM_ENT-1:0] alloc_oh;
   logic [NUM_ENT-1:0] sel_oh;
   logic [NUM_ENT-1:0] free_oh;
   logic [IDX_W-1:0]   sel_idx;
   logic               sel_any;
   logic               alloc_fire;
   logic               load_en;
   logic [CNT_W-1:0]   cnt_c;

   logic               exec_b_q;
   logic [FUNC_W-1:0]  func_q;
   logic [IDX_W-1:0]   idx_q;
   logic [DATA_W-1:0]  v1_q;
   logic [DATA_W-1:0]  v2_q;
   logic [TAG_W-1:0]   rob_q;
   logic [REG_W-1:0]   rd_q;

   // Status vectors from registered state and the lowest free slot
   always_comb begin
      busy_v   = '0;
      elig_v   = '0;
      alloc_oh = '0;
      for (int i = 0; i < NUM_ENT; i++) begin
         busy_v[i] = ent_q[i].busy;
         elig_v[i] = ent_q[i].busy & ent_q[i].rdy1 & ent_q[i].rdy2;
      end
      for (int i = NUM_ENT - 1; i >= 0; i--) begin
         if (!ent_q[i].busy) begin
            alloc_oh    = '0;
            alloc_oh[i] = 1'b1;
         end
      end
   end

   // A slot being freed this cycle is still busy here, so the new op lands
   // in a different slot.
   assign bus.alloc_ready = ~&busy_v;
   assign alloc_fire      = bus.alloc_valid & bus.alloc_ready;
   assign load_en         = ~exec_b_q | bus.exec_ready;
   assign free_oh         = (load_en && sel_any) ? sel_oh : '0;

   rs_age_select #(
      .NUM_ENT (NUM_ENT),
      .IDX_W   (IDX_W)
   ) u_age (
      .clk_i      (clk1),
      .rst_ni     (rst_n),
      .flush_i    (bus.flush),
      .alloc_i    (alloc_fire),
      .alloc_oh_i (alloc_oh),
      .free_oh_i  (free_oh),
      .elig_i     (elig_v),
      .sel_oh_o   (sel_oh),
      .sel_idx_o  (sel_idx),
      .sel_any_o  (sel_any)
   );

   // Entry next state: CDB wakeup, release on dispatch, allocation with bypass
   always_comb begin
      for (int i = 0; i < NUM_ENT; i++) begin
         ent_d[i] = ent_q[i];
         if (ent_q[i].busy &&
             tag_hit(bus.cdb_valid, bus.cdb_rob, ent_q[i].rdy1, ent_q[i].q1)) begin
            ent_d[i].rdy1 = 1'b1;
            ent_d[i].v1   = bus.cdb_data;
         end
         if (ent_q[i].busy &&
             tag_hit(bus.cdb_valid, bus.cdb_rob, ent_q[i].rdy2, ent_q[i].q2)) begin
            ent_d[i].rdy2 = 1'b1;
            ent_d[i].v2   = bus.cdb_data;
         end
         if (free_oh[i]) ent_d[i].busy = 1'b0;
         if (alloc_fire && alloc_oh[i]) begin
            ent_d[i].busy = 1'b1;
            ent_d[i].func = bus.alloc_func;
            ent_d[i].rd   = bus.alloc_rd;
            ent_d[i].rob  = bus.alloc_rob;
            ent_d[i].q1   = bus.alloc_q1;
            ent_d[i].q2   = bus.alloc_q2;
            ent_d[i].rdy1 = bus.alloc_rdy1 |
                            tag_hit(bus.cdb_valid, bus.cdb_rob, bus.alloc_rdy1, bus.alloc_q1);
            ent_d[i].rdy2 = bus.alloc_rdy2 |
                            tag_hit(bus.cdb_valid, bus.cdb_rob, bus.alloc_rdy2, bus.alloc_q2);
            ent_d[i].v1   = bus.alloc_rdy1 ? bus.alloc_v1 : bus.cdb_data;
            ent_d[i].v2   = bus.alloc_rdy2 ? bus.alloc_v2 : bus.cdb_data;
         end
      end
   end

   // Entry storage; only the busy flags need clearing on reset or flush
   always_ff @(posedge clk1) begin
      if (!rst_n || bus.flush) begin
         for (int i = 0; i < NUM_ENT; i++) ent_q[i].busy <= 1'b0;
      end else begin
         for (int i = 0; i < NUM_ENT; i++) ent_q[i] <= ent_d[i];
      end
   end

   // Dispatch register: reloads when empty or accepted, holds while stalled
   always_ff @(posedge clk1) begin
      if (!rst_n || bus.flush) begin
         exec_b_q <= 1'b0;
         func_q   <= '0;
         idx_q    <= '0;
         v1_q     <= '0;
         v2_q     <= '0;
         rob_q    <= '0;
         rd_q     <= '0;
      end else if (load_en) begin
         exec_b_q <= sel_any;
         if (sel_any) begin
            func_q <= ent_q[sel_idx].func;
            idx_q  <= sel_idx;
            v1_q   <= ent_q[sel_idx].v1;
            v2_q   <= ent_q[sel_idx].v2;
            rob_q  <= ent_q[sel_idx].rob;
            rd_q   <= ent_q[sel_idx].rd;
         end
      end
   end

   // Occupancy counts busy entries plus the op held for the exec unit
   always_comb begin
      cnt_c = CNT_W'(exec_b_q);
      for (int i = 0; i < NUM_ENT; i++) cnt_c = cnt_c + CNT_W'(busy_v[i]);
   end

   assign bus.exec_b   = exec_b_q;
   assign bus.func     = func_q;
   assign bus.rs_index = idx_q;
   assign bus.rs1_data = v1_q;
   assign bus.rs2_data = v2_q;
   assign bus.rob_ind  = rob_q;
   assign bus.rd       = rd_q;
   assign bus.busy_cnt = cnt_c;

endmodule

// File: tb/tb_rs_dispatch.sv
// Bench for rs_dispatch: directed ops, an age-ordered slot model checked on
// every negative edge, and literal expectations at key points.
module tb_rs_dispatch;
   import tomasulo_pkg::*;

   localparam int N = 3;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   rs_dispatch_if #(.NUM_ENT(N)) bus ();
   rs_dispatch #(.NUM_ENT(N)) dut (.clk1(clk), .rst_n(rst_n), .bus(bus));

   int total = 0;
   int bad   = 0;
   bit chk_en = 1'b0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   typedef struct {
      bit busy; int func; int rd; int rob;
      bit r1; int v1; int q1;
      bit r2; int v2; int q2;
      int seq;
   } ment_t;

   ment_t m [N];
   bit    m_eb;
   int    m_func, m_idx, m_v1, m_v2, m_rob, m_rd;
   int    m_seq = 0;

   function automatic int m_count();
      int c;
      c = m_eb ? 1 : 0;
      for (int i = 0; i < N; i++) if (m[i].busy) c++;
      return c;
   endfunction

   function automatic bit m_ready();
      for (int i = 0; i < N; i++) if (!m[i].busy) return 1'b1;
      return 1'b0;
   endfunction

   initial begin
      for (int i = 0; i < N; i++) m[i] = '{default: 0};
      m_eb = 0; m_func = 0; m_idx = 0; m_v1 = 0; m_v2 = 0; m_rob = 0; m_rd = 0;
   end

   always @(posedge clk) begin : model
      int aslot;
      int sel;
      bit take;
      if (!rst_n || bus.flush) begin
         for (int i = 0; i < N; i++) m[i] = '{default: 0};
         m_eb = 0; m_func = 0; m_idx = 0; m_v1 = 0; m_v2 = 0; m_rob = 0; m_rd = 0;
      end else begin
         aslot = -1;
         sel   = -1;
         for (int i = 0; i < N; i++) if (!m[i].busy && aslot < 0) aslot = i;
         for (int i = 0; i < N; i++)
            if (m[i].busy && m[i].r1 && m[i].r2 && (sel < 0 || m[i].seq < m[sel].seq)) sel = i;
         take = !m_eb || bus.exec_ready;
         if (bus.cdb_valid) begin
            for (int i = 0; i < N; i++) begin
               if (m[i].busy && !m[i].r1 && m[i].q1 == int'(bus.cdb_rob)) begin
                  m[i].r1 = 1; m[i].v1 = int'(bus.cdb_data);
               end
               if (m[i].busy && !m[i].r2 && m[i].q2 == int'(bus.cdb_rob)) begin
                  m[i].r2 = 1; m[i].v2 = int'(bus.cdb_data);
               end
            end
         end
         if (take) begin
            m_eb = (sel >= 0);
            if (sel >= 0) begin
               m_func = m[sel].func; m_idx = sel; m_v1 = m[sel].v1; m_v2 = m[sel].v2;
               m_rob = m[sel].rob; m_rd = m[sel].rd;
               m[sel].busy = 0;
            end
         end
         if (bus.alloc_valid && aslot >= 0) begin
            m[aslot].busy = 1;
            m[aslot].func = int'(bus.alloc_func);
            m[aslot].rd   = int'(bus.alloc_rd);
            m[aslot].rob  = int'(bus.alloc_rob);
            m[aslot].q1   = int'(bus.alloc_q1);
            m[aslot].q2   = int'(bus.alloc_q2);
            m[aslot].r1   = bus.alloc_rdy1 || (bus.cdb_valid && bus.cdb_rob == bus.alloc_q1);
            m[aslot].r2   = bus.alloc_rdy2 || (bus.cdb_valid && bus.cdb_rob == bus.alloc_q2);
            m[aslot].v1   = bus.alloc_rdy1 ? int'(bus.alloc_v1) : int'(bus.cdb_data);
            m[aslot].v2   = bus.alloc_rdy2 ? int'(bus.alloc_v2) : int'(bus.cdb_data);
            m[aslot].seq  = m_seq;
            m_seq++;
         end
      end
   end

   // ---------------- compare process ----------------
   always @(negedge clk) begin
      if (chk_en) begin
         check("cmp exec_b", 32'(bus.exec_b), 32'(m_eb));
         check("cmp alloc_ready", 32'(bus.alloc_ready), 32'(m_ready()));
         check("cmp busy_cnt", 32'(bus.busy_cnt), 32'(m_count()));
         if (m_eb) begin
            check("cmp func", 32'(bus.func), 32'(m_func));
            check("cmp rs_index", 32'(bus.rs_index), 32'(m_idx));
            check("cmp rs1_data", 32'(bus.rs1_data), 32'(m_v1));
            check("cmp rs2_data", 32'(bus.rs2_data), 32'(m_v2));
            check("cmp rob_ind", 32'(bus.rob_ind), 32'(m_rob));
            check("cmp rd", 32'(bus.rd), 32'(m_rd));
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic put(input int f, input int rdv, input int rob,
                      input bit r1, input int v1, input int q1,
                      input bit r2, input int v2, input int q2);
      bus.alloc_valid = 1'b1;
      bus.alloc_func  = 4'(f);
      bus.alloc_rd    = 4'(rdv);
      bus.alloc_rob   = 3'(rob);
      bus.alloc_rdy1  = r1;
      bus.alloc_v1    = 8'(v1);
      bus.alloc_q1    = 3'(q1);
      bus.alloc_rdy2  = r2;
      bus.alloc_v2    = 8'(v2);
      bus.alloc_q2    = 3'(q2);
   endtask

   task automatic bcast(input int tag, input int data);
      bus.cdb_valid = 1'b1;
      bus.cdb_rob   = 3'(tag);
      bus.cdb_data  = 8'(data);
   endtask

   task automatic quiet();
      bus.alloc_valid = 1'b0;
      bus.cdb_valid   = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0;
      bus.flush = 1'b0;
      bus.exec_ready = 1'b1;
      put(0, 0, 0, 0, 0, 0, 0, 0, 0);
      bcast(0, 0);
      quiet();

      // reset
      cyc();
      chk_en = 1'b1;
      cyc();
      rst_n = 1'b1;
      check("rst exec_b", 32'(bus.exec_b), 0);
      check("rst func", 32'(bus.func), 0);
      check("rst rs_index", 32'(bus.rs_index), 0);
      check("rst rs1_data", 32'(bus.rs1_data), 0);
      check("rst rs2_data", 32'(bus.rs2_data), 0);
      check("rst rob_ind", 32'(bus.rob_ind), 0);
      check("rst rd", 32'(bus.rd), 0);
      check("rst busy_cnt", 32'(bus.busy_cnt), 0);
      check("rst alloc_ready", 32'(bus.alloc_ready), 1);

      // 1: ready ADD dispatches one cycle after allocation
      put(FUNC_ADD, 2, 1, 1, 5, 0, 1, 3, 0);
      cyc(); quiet();
      check("t1 exec_b early", 32'(bus.exec_b), 0);
      check("t1 busy_cnt held", 32'(bus.busy_cnt), 1);
      cyc();
      check("t1 exec_b", 32'(bus.exec_b), 1);
      check("t1 func", 32'(bus.func), 0);
      check("t1 rs_index", 32'(bus.rs_index), 0);
      check("t1 rs1_data", 32'(bus.rs1_data), 5);
      check("t1 rs2_data", 32'(bus.rs2_data), 3);
      check("t1 rob_ind", 32'(bus.rob_ind), 1);
      check("t1 rd", 32'(bus.rd), 2);
      cyc();
      check("t1 exec_b after accept", 32'(bus.exec_b), 0);
      check("t1 busy_cnt after accept", 32'(bus.busy_cnt), 0);

      // 2: MUL waits for tag 4, wakes from the CDB
      put(FUNC_MUL, 3, 2, 0, 0, 4, 1, 2, 0);
      cyc(); quiet();
      cyc();
      bcast(4, 7);
      cyc(); quiet();
      check("t2 exec_b at wake", 32'(bus.exec_b), 0);
      cyc();
      check("t2 exec_b", 32'(bus.exec_b), 1);
      check("t2 rs1_data", 32'(bus.rs1_data), 7);
      check("t2 func", 32'(bus.func), 2);
      cyc();

      // 3: allocation bypass from a same-cycle broadcast
      put(FUNC_SUB, 4, 3, 1, 1, 0, 0, 0, 6);
      bcast(6, 9);
      cyc(); quiet();
      cyc();
      check("t3 exec_b", 32'(bus.exec_b), 1);
      check("t3 rs2_data", 32'(bus.rs2_data), 9);
      check("t3 rs1_data", 32'(bus.rs1_data), 1);
      cyc();

      // 4: fill the bank, extra alloc ignored, then oldest-first drain
      bus.exec_ready = 1'b0;
      put(FUNC_DIV, 9, 1, 0, 0, 5, 1, 10, 0); cyc();
      put(FUNC_LD, 10, 2, 0, 0, 5, 1, 20, 0); cyc();
      put(FUNC_ST, 11, 3, 0, 0, 5, 1, 30, 0); cyc();
      check("t4 alloc_ready full", 32'(bus.alloc_ready), 0);
      put(FUNC_ADD, 12, 4, 1, 1, 0, 1, 1, 0); cyc(); quiet();
      check("t4 busy_cnt full", 32'(bus.busy_cnt), 3);
      check("t4 exec_b idle", 32'(bus.exec_b), 0);
      bcast(5, 11);
      bus.exec_ready = 1'b1;
      cyc(); quiet();
      cyc();
      check("t4 first rob", 32'(bus.rob_ind), 1);
      check("t4 first rs1", 32'(bus.rs1_data), 11);
      cyc();
      check("t4 second rob", 32'(bus.rob_ind), 2);
      check("t4 second func", 32'(bus.func), 4);
      cyc();
      check("t4 third rob", 32'(bus.rob_ind), 3);
      check("t4 third func", 32'(bus.func), 5);
      check("t4 third rs_index", 32'(bus.rs_index), 2);
      cyc();
      check("t4 drained", 32'(bus.exec_b), 0);

      // 5: stall holds outputs while a younger op becomes ready
      bus.exec_ready = 1'b0;
      put(FUNC_ADD, 1, 1, 1, 1, 0, 1, 2, 0); cyc();
      put(FUNC_SUB, 2, 2, 0, 0, 3, 1, 4, 0); cyc(); quiet();
      check("t5 held rob c1", 32'(bus.rob_ind), 1);
      bcast(3, 8);
      cyc(); quiet();
      for (int k = 0; k < 3; k++) begin
         check("t5 held exec_b", 32'(bus.exec_b), 1);
         check("t5 held rob", 32'(bus.rob_ind), 1);
         check("t5 held rs1", 32'(bus.rs1_data), 1);
         if (k < 2) cyc();
      end
      bus.exec_ready = 1'b1;
      cyc();
      check("t5 next rob", 32'(bus.rob_ind), 2);
      check("t5 next rs1", 32'(bus.rs1_data), 8);
      check("t5 next rs_index", 32'(bus.rs_index), 1);
      cyc();

      // 6: flush with three pending entries and a held dispatch
      bus.exec_ready = 1'b0;
      put(FUNC_ADD, 1, 1, 1, 1, 0, 1, 1, 0); cyc();
      put(FUNC_MUL, 2, 2, 0, 0, 6, 1, 2, 0); cyc();
      put(FUNC_DIV, 3, 3, 1, 3, 0, 0, 0, 6); cyc();
      put(FUNC_LD, 4, 4, 0, 0, 7, 1, 4, 0); cyc(); quiet();
      check("t6 busy_cnt before flush", 32'(bus.busy_cnt), 4);
      check("t6 exec_b before flush", 32'(bus.exec_b), 1);
      bus.flush = 1'b1;
      cyc();
      bus.flush = 1'b0;
      check("t6 exec_b flushed", 32'(bus.exec_b), 0);
      check("t6 busy_cnt flushed", 32'(bus.busy_cnt), 0);
      check("t6 alloc_ready flushed", 32'(bus.alloc_ready), 1);
      bus.exec_ready = 1'b1;
      bcast(6, 1);
      cyc(); quiet();
      cyc(); cyc();
      check("t6 stale wake no dispatch", 32'(bus.exec_b), 0);

      // 7: reset drops a held dispatch
      bus.exec_ready = 1'b0;
      put(FUNC_ST, 5, 5, 1, 6, 0, 1, 7, 0); cyc(); quiet();
      cyc();
      check("t7 exec_b held", 32'(bus.exec_b), 1);
      rst_n = 1'b0;
      cyc();
      rst_n = 1'b1;
      check("t7 exec_b after reset", 32'(bus.exec_b), 0);
      check("t7 rs1 after reset", 32'(bus.rs1_data), 0);
      bus.exec_ready = 1'b1;
      cyc(); cyc();

      chk_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
